median_row_filter: RTL and testbench

//  3x3 per-channel median (denoise) stage feeding the sobel edge stage. Accepts one packed
//  RGB image row per handshake, keeps a 3-row window, filters it column-serially (one pixel
//  per cycle), and presents each filtered row on row_out in the packing the sobel stage consumes.

---
 rtl/median_row_filter.sv | 186 ++++++++++++++++++
 tb/tb_median_row_filter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/median_row_filter.sv
// median_row_filter: 3x3 per-channel median over a sliding 3-row window.
// Rows arrive whole on row_in and are filtered one pixel per cycle. Each
// finished row is presented on row_out with a one-cycle out_valid pulse.
// Top/bottom borders replicate the edge row; left/right borders clamp the
// column index.
//
// Handshake: a row is taken on any rising edge where SET && in_ready.
// in_ready is high only in IDLE, PRIME and WAIT, and low while RST is high.
// SET is ignored whenever in_ready is low, and the bench may hold it high.
// out_valid and frame_done are single-cycle pulses. frame_done follows the
// last out_valid of a frame by exactly one cycle.
module median_row_filter #(
  parameter int ROW   = 256,
  parameter int NROWS = 256,
  parameter int WIDTH = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   SET,
  input  logic [ROW*WIDTH*3-1:0] row_in,
  output logic                   in_ready,
  output logic [ROW*WIDTH*3-1:0] row_out,
  output logic                   out_valid,
  output logic                   frame_done,
  output logic [2:0]             o_dbg_state
);

  localparam int PW = 3 * WIDTH;
  localparam int RW = ROW * PW;
  localparam int CW = (ROW > 1) ? $clog2(ROW) : 1;
  localparam int NW = $clog2(NROWS + 1);
  localparam logic [CW-1:0] LAST_COL = CW'(ROW - 1);
  localparam logic [NW-1:0] NROWS_C  = NW'(NROWS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRIME = 3'd1,
    S_PROC  = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          r_state, w_next;
  logic [RW-1:0]   r_top, r_mid, r_bot, r_res, r_row_out;
  logic [CW-1:0]   r_col;
  logic [NW-1:0]   r_rcnt, r_ocnt;
  logic            r_out_valid, r_frame_done;
  logic            w_accept, w_last_col;
  int              w_il, w_ic, w_ir;
  logic [PW-1:0]   w_nb [9];
  logic [PW-1:0]   w_pix;
  logic [RW-1:0]   w_res_full;

  // Exact 5th-smallest of nine unsigned values (full bubble sort).
  function automatic logic [WIDTH-1:0] med9(input logic [9*WIDTH-1:0] v);
    logic [WIDTH-1:0] a [9];
    logic [WIDTH-1:0] t;
    for (int i = 0; i < 9; i++) a[i] = v[i*WIDTH +: WIDTH];
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8 - i; j++) begin
        if (a[j] > a[j+1]) begin
          t      = a[j];
          a[j]   = a[j+1];
          a[j+1] = t;
        end
      end
    end
    return a[4];
  endfunction

  assign in_ready    = !RST && ((r_state == S_IDLE) || (r_state == S_PRIME) ||
                                (r_state == S_WAIT));
  assign w_accept    = SET && in_ready;
  assign w_last_col  = (r_col == LAST_COL);
  assign row_out     = r_row_out;
  assign out_valid   = r_out_valid;
  assign frame_done  = r_frame_done;
  assign o_dbg_state = r_state;

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_PRIME;
      S_PRIME: if (w_accept) w_next = S_PROC;
      S_PROC: begin
        if (w_last_col) begin
          if (r_ocnt + 1'b1 == NROWS_C) w_next = S_DONE;
          else if (r_rcnt == NROWS_C)   w_next = S_PROC;
          else                          w_next = S_WAIT;
        end
      end
      S_WAIT:  if (w_accept) w_next = S_PROC;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Median of the 3x3 neighbourhood around r_col, merged into the row buffer.
  always_comb begin
    logic [9*WIDTH-1:0] vec;
    w_ic  = int'(r_col);
    w_il  = (r_col == '0) ? 0 : w_ic - 1;
    w_ir  = w_last_col ? w_ic : w_ic + 1;
    w_nb[0] = r_top[(ROW-1-w_il)*PW +: PW];
    w_nb[1] = r_top[(ROW-1-w_ic)*PW +: PW];
    w_nb[2] = r_top[(ROW-1-w_ir)*PW +: PW];
    w_nb[3] = r_mid[(ROW-1-w_il)*PW +: PW];
    w_nb[4] = r_mid[(ROW-1-w_ic)*PW +: PW];
    w_nb[5] = r_mid[(ROW-1-w_ir)*PW +: PW];
    w_nb[6] = r_bot[(ROW-1-w_il)*PW +: PW];
    w_nb[7] = r_bot[(ROW-1-w_ic)*PW +: PW];
    w_nb[8] = r_bot[(ROW-1-w_ir)*PW +: PW];
    w_pix   = '0;
    for (int ch = 0; ch < 3; ch++) begin
      vec = '0;
      for (int n = 0; n < 9; n++) vec[n*WIDTH +: WIDTH] = w_nb[n][ch*WIDTH +: WIDTH];
      w_pix[ch*WIDTH +: WIDTH] = med9(vec);
    end
    w_res_full = r_res;
    w_res_full[(ROW-1-w_ic)*PW +: PW] = w_pix;
  end

  // Window, counters, result buffer and output pulses.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_top        <= '0;
      r_mid        <= '0;
      r_bot        <= '0;
      r_res        <= '0;
      r_row_out    <= '0;
      r_col        <= '0;
      r_rcnt       <= '0;
      r_ocnt       <= '0;
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_out_valid  <= 1'b0;
      r_frame_done <= (r_state == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_top  <= row_in;
            r_mid  <= row_in;
            r_rcnt <= NW'(1);
            r_ocnt <= '0;
          end
        end
        S_PRIME: begin
          if (w_accept) begin
            r_bot  <= row_in;
            r_rcnt <= NW'(2);
            r_col  <= '0;
          end
        end
        S_PROC: begin
          r_res <= w_res_full;
          if (w_last_col) begin
            r_row_out   <= w_res_full;
            r_out_valid <= 1'b1;
            r_ocnt      <= r_ocnt + 1'b1;
            r_top       <= r_mid;
            r_mid       <= r_bot;
            r_col       <= '0;
          end else begin
            r_col <= r_col + 1'b1;
          end
        end
        S_WAIT: begin
          if (w_accept) begin
            r_bot  <= row_in;
            r_rcnt <= r_rcnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_median_row_filter.sv
// Directed bench for median_row_filter with ROW=4, NROWS=3, WIDTH=8.
module tb_median_row_filter;

  localparam int ROW   = 4;
  localparam int NROWS = 3;
  localparam int WIDTH = 8;
  localparam int RW    = ROW * WIDTH * 3;

  logic          CLK, RST, SET;
  logic [RW-1:0] row_in, row_out;
  logic          in_ready, out_valid, frame_done;
  logic [2:0]    dbg_state;

  int            total = 0;
  int            bad   = 0;
  logic [RW-1:0] last_row;

  median_row_filter #(.ROW(ROW), .NROWS(NROWS), .WIDTH(WIDTH)) dut (
    .CLK(CLK), .RST(RST), .SET(SET), .row_in(row_in), .in_ready(in_ready),
    .row_out(row_out), .out_valid(out_valid), .frame_done(frame_done),
    .o_dbg_state(dbg_state)
  );

  // Clock and reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] mk(input logic [23:0] p0, input logic [23:0] p1,
                                       input logic [23:0] p2, input logic [23:0] p3);
    return {p0, p1, p2, p3};
  endfunction

  function automatic logic [RW-1:0] flat(input logic [7:0] v);
    return {4{v, v, v}};
  endfunction

  function automatic logic [23:0] dp(input logic [7:0] v);
    return {v, 8'h80, 8'hFF - v};
  endfunction

  // Driver: present a row and hold SET until it is taken.
  task automatic send_row(input logic [RW-1:0] r, input string tag);
    int n;
    n = 0;
    SET = 1'b1;
    row_in = r;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_ready"}, RW'(in_ready), RW'(1));
    step();
    SET = 1'b0;
  endtask

  // Expect one filtered row exactly ROW cycles from now.
  task automatic expect_row(input logic [RW-1:0] exp, input logic exp_ir_end, input string tag);
    for (int i = 1; i <= ROW; i++) begin
      step();
      if (i < ROW) begin
        chk({tag, "_novalid"}, RW'(out_valid), RW'(0));
        chk({tag, "_busy"},    RW'(in_ready),  RW'(0));
        chk({tag, "_hold"},    row_out,        last_row);
      end else begin
        chk({tag, "_valid"},   RW'(out_valid), RW'(1));
        chk({tag, "_data"},    row_out,        exp);
        chk({tag, "_ready"},   RW'(in_ready),  RW'(exp_ir_end));
        last_row = exp;
      end
      chk({tag, "_nofd"}, RW'(frame_done), RW'(0));
    end
  endtask

  task automatic run_frame(input logic [RW-1:0] r0, input logic [RW-1:0] r1,
                           input logic [RW-1:0] r2, input logic [RW-1:0] e0,
                           input logic [RW-1:0] e1, input logic [RW-1:0] e2,
                           input string tag);
    send_row(r0, {tag, "_r0"});
    send_row(r1, {tag, "_r1"});
    expect_row(e0, 1'b1, {tag, "_o0"});
    send_row(r2, {tag, "_r2"});
    expect_row(e1, 1'b0, {tag, "_o1"});
    expect_row(e2, 1'b0, {tag, "_o2"});
    step();
    chk({tag, "_fd"},     RW'(frame_done), RW'(1));
    chk({tag, "_fd_nov"}, RW'(out_valid),  RW'(0));
    chk({tag, "_fd_rdy"}, RW'(in_ready),   RW'(1));
  endtask

  initial begin
    logic exp_ir;
    RST = 1'b1;
    SET = 1'b1;
    row_in = flat(8'h55);
    last_row = '0;

    // Reset state
    step();
    step();
    chk("rst_ready", RW'(in_ready),   RW'(0));
    chk("rst_valid", RW'(out_valid),  RW'(0));
    chk("rst_fd",    RW'(frame_done), RW'(0));
    chk("rst_row",   row_out,         '0);
    chk("rst_state", RW'(dbg_state),  RW'(0));
    RST = 1'b0;
    SET = 1'b0;
    #1;
    chk("rst_rel_ready", RW'(in_ready), RW'(1));

    // Flat frame
    run_frame(flat(8'h40), flat(8'h40), flat(8'h40),
              flat(8'h40), flat(8'h40), flat(8'h40), "flat");

    // Ramp frame back to back: left/right clamp keeps the ramp intact
    run_frame(mk(24'h0A0A0A, 24'h141414, 24'h1E1E1E, 24'h282828),
              mk(24'h0A0A0A, 24'h141414, 24'h1E1E1E, 24'h282828),
              mk(24'h0A0A0A, 24'h141414, 24'h1E1E1E, 24'h282828),
              mk(24'h0A0A0A, 24'h141414, 24'h1E1E1E, 24'h282828),
              mk(24'h0A0A0A, 24'h141414, 24'h1E1E1E, 24'h282828),
              mk(24'h0A0A0A, 24'h141414, 24'h1E1E1E, 24'h282828), "ramp");

    // Distinct values; R=v, G=const, B=255-v
    run_frame(mk(dp(8'd5),  dp(8'd90), dp(8'd17), dp(8'd60)),
              mk(dp(8'd33), dp(8'd2),  dp(8'd71), dp(8'd44)),
              mk(dp(8'd80), dp(8'd25), dp(8'd9),  dp(8'd50)),
              mk(dp(8'd5),  dp(8'd17), dp(8'd60), dp(8'd60)),
              mk(dp(8'd33), dp(8'd25), dp(8'd44), dp(8'd50)),
              mk(dp(8'd33), dp(8'd25), dp(8'd25), dp(8'd50)), "mix");

    // Single impulse is removed entirely
    run_frame('0, mk(24'h0, 24'h0, 24'hFF0000, 24'h0), '0,
              '0, '0, '0, "imp");

    // SET held high with row_in changing every cycle
    step();
    chk("seth_fd_clear", RW'(frame_done), RW'(0));
    for (int t = 0; t <= 17; t++) begin
      exp_ir = (t <= 1) || (t == 6) || (t >= 16);
      if (t == 6)  last_row = flat(8'd8);
      if (t == 11) last_row = flat(8'd16);
      if (t == 15) last_row = flat(8'd56);
      chk($sformatf("seth_ready_t%0d", t), RW'(in_ready),   RW'(exp_ir));
      chk($sformatf("seth_valid_t%0d", t), RW'(out_valid),
          RW'((t == 6) || (t == 11) || (t == 15)));
      chk($sformatf("seth_fd_t%0d", t),    RW'(frame_done), RW'(t == 16));
      chk($sformatf("seth_row_t%0d", t),   row_out,         last_row);
      SET = (t < 16);
      row_in = flat(8'(8 * (t + 1)));
      step();
    end
    SET = 1'b0;

    // Reset in the middle of processing row 0
    send_row(flat(8'h40), "mrst_r0");
    send_row(flat(8'h40), "mrst_r1");
    step();
    step();
    chk("mrst_state_proc", RW'(dbg_state), RW'(2));
    RST = 1'b1;
    SET = 1'b1;
    step();
    chk("mrst_ready_hi", RW'(in_ready),  RW'(0));
    chk("mrst_row",      row_out,        '0);
    chk("mrst_valid",    RW'(out_valid), RW'(0));
    chk("mrst_state",    RW'(dbg_state), RW'(0));
    RST = 1'b0;
    SET = 1'b0;
    #1;
    chk("mrst_ready", RW'(in_ready), RW'(1));
    last_row = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mrst_idle_nov", RW'(out_valid), RW'(0));
      chk("mrst_idle_row", row_out,        '0);
    end
    run_frame(flat(8'h40), flat(8'h40), flat(8'h40),
              flat(8'h40), flat(8'h40), flat(8'h40), "fresh");
    step();
    chk("end_fd_pulse", RW'(frame_done), RW'(0));
    chk("end_row_hold", row_out,         flat(8'h40));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
